mux2_rr_arbiter: RTL and testbench
==================================

// Module: mux2_rr_arbiter
// PURPOSE
//  - Shares one nbits-wide output stream between two val/rdy requester streams.
//  - Round-robin arbitration; the winner's message passes through a 2:1 mux
//    datapath into a one-entry output register.
//  - Sits between two producers and a single downstream consumer/channel.
//  - Exports the mux select so benches can observe arbitration decisions.
// PARAMETERS
//  nbits   8   width of every message port
// PORTS
//  clk       in   1      clock; all state updates on posedge
//  reset     in   1      asynchronous, active-high reset
//  in0_val   in   1      requester 0 has a valid message
//  in0_rdy   out  1      arbiter accepts in0_msg this cycle
//  in0_msg   in   nbits  requester 0 message
//  in1_val   in   1      requester 1 has a valid message
//  in1_rdy   out  1      arbiter accepts in1_msg this cycle
//  in1_msg   in   nbits  requester 1 message
//  out_val   out  1      output register holds a valid message
//  out_rdy   in   1      consumer accepts out_msg this cycle
//  out_msg   out  nbits  registered output message
//  sel       out  1      current mux select / grant index (0 = in0, 1 = in1)
// BEHAVIOUR
//  - Transfer on a port happens on a clk edge only when val && rdy are both high.
//  - State: full (output register valid), prio (favoured requester), out_msg.
//  - Reset (async, active-high): full=0, prio=0, out_msg=0.
//    Outputs: out_val=0, in0_rdy=0, in1_rdy=0, sel=0.
//    While reset is high, both in*_rdy are forced to 0.
//  - accept = !full || out_rdy. Pipe behaviour: a simultaneous dequeue and
//    enqueue is allowed when full.
//  - Grant (combinational):
//    - both val: sel = prio;
//    - only inX_val: sel = X;
//    - neither: sel = prio.
//  - in0_rdy = accept && in0_val && sel==0; in1_rdy = accept && in1_val && sel==1.
//    At most one rdy is ever high.
//  - On input transfer from requester X: out_msg <= mux(sel) msg; full <= 1;
//    prio <= ~X. Latency is 1 cycle from input transfer to out_val.
//  - Output dequeue with no input transfer: full <= 0. out_msg holds its value.
//  - No transfer on any port: all state holds.
//  - A requester never waits more than one grant to the other requester while
//    its val stays high.
//  - out_val = full. No combinational path from in*_val to out_val.
//  - out_rdy low while full: both in*_rdy low; out_msg/out_val are stable.
//  - Reset asserted mid-operation drops any buffered message immediately.
//    No transfer is reported on the reset-release cycle.
// STRUCTURE
//  - Shared package: message width default; grant index encoding
//    (GRANT_IN0=1'b0, GRANT_IN1=1'b1).
//  - One sub-module: mux2_nbit (parameterized nbits 2:1 mux, in0/in1/sel/out),
//    instantiated for the datapath.
//  - Control (grant, prio, full) stays in this module.
// TESTING
//  - Reset: assert reset mid-stream with full=1
//    -> out_val=0, in0_rdy=in1_rdy=0 immediately, without waiting for a clk edge.
//  - Single requester: in0_val=1, msg=8'hA5, out_rdy=1
//    -> in0_rdy=1, next cycle out_val=1 and out_msg=8'hA5, sel=0.
//  - Contention: both val for 4 cycles, in0=8'h11, in1=8'h22, out_rdy=1
//    -> out_msg sequence 11,22,11,22 (prio starts at 0).
//  - Backpressure: out_rdy=0 with full=1, both val=1
//    -> both rdy=0 and out_msg held for 3 cycles.
//    Then out_rdy=1 -> same-cycle dequeue and enqueue, out_val stays 1.
//  - Alternating idle: in1 only (8'h33), then in0 only (8'h44)
//    -> each granted in the cycle it is valid, and prio tracks ~last winner.
//  - Randomized val/out_rdy over 1000 cycles against a reference model
//    -> no lost or duplicated messages, and no two consecutive in0 grants
//       while in1_val is held.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_rr_arbiter_pkg
//  Purpose  : Shared definitions for the two-requester round-robin arbiter:
//             default message width and the grant index encoding.
//  Ports    : (package, none)
//  Revision : 1.0  initial release
// ============================================================================
package mux2_rr_arbiter_pkg;

   localparam int unsigned NBITS_DEFAULT = 8;

   // Grant index doubles as the datapath mux select.
   typedef enum logic {
      GRANT_IN0 = 1'b0,
      GRANT_IN1 = 1'b1
   } grant_e;

endpackage
`default_nettype wire

// File: rtl/mux2_nbit.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_nbit
//  Purpose  : Parameterized nbits-wide 2:1 multiplexer.
//  Ports    : in0  - data selected when sel = 0
//             in1  - data selected when sel = 1
//             sel  - select
//             out  - selected data
//  Revision : 1.0  initial release
// ============================================================================
module mux2_nbit
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int unsigned nbits = NBITS_DEFAULT
) (
   input  logic [nbits-1:0] in0,
   input  logic [nbits-1:0] in1,
   input  logic             sel,
   output logic [nbits-1:0] out
);

   assign out = sel ? in1 : in0;

endmodule
`default_nettype wire

// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_rr_arbiter
//  Purpose  : Shares one nbits-wide val/rdy output stream between two
//             requesters using round-robin arbitration. The winner's message
//             passes through a 2:1 mux into a one-entry output register that
//             behaves as a pipe (dequeue and enqueue in the same cycle).
//  Ports    : clk, reset            - clock, async active-high reset
//             in0_val/in0_rdy/in0_msg - requester 0 stream
//             in1_val/in1_rdy/in1_msg - requester 1 stream
//             out_val/out_rdy/out_msg - registered output stream
//             sel                   - current grant index (0 = in0, 1 = in1)
//  Revision : 1.0  initial release
// ============================================================================
module mux2_rr_arbiter
   import mux2_rr_arbiter_pkg::*;
#(
   parameter int unsigned nbits = NBITS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_val,
   output logic             in0_rdy,
   input  logic [nbits-1:0] in0_msg,
   input  logic             in1_val,
   output logic             in1_rdy,
   input  logic [nbits-1:0] in1_msg,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [nbits-1:0] out_msg,
   output logic             sel
);

   logic             full_q, full_d;
   grant_e           prio_q, prio_d;
   logic [nbits-1:0] msg_q,  msg_d;

   grant_e           grant_w;
   logic             accept_w;
   logic             xfer_w;
   logic [nbits-1:0] mux_out_w;

   // Room in the output register now, or it drains on this same edge.
   assign accept_w = !full_q || out_rdy;

   always_comb begin
      grant_w = prio_q;
      if (in0_val && !in1_val) begin
         grant_w = GRANT_IN0;
      end else if (in1_val && !in0_val) begin
         grant_w = GRANT_IN1;
      end
   end

   // Ready is gated by reset so nothing is accepted while reset is asserted.
   assign in0_rdy = !reset && accept_w && in0_val && (grant_w == GRANT_IN0);
   assign in1_rdy = !reset && accept_w && in1_val && (grant_w == GRANT_IN1);
   assign xfer_w  = in0_rdy || in1_rdy;

   assign sel     = reset ? GRANT_IN0 : grant_w;
   assign out_val = full_q;
   assign out_msg = msg_q;

   mux2_nbit #(
      .nbits (nbits)
   ) u_mux (
      .in0 (in0_msg),
      .in1 (in1_msg),
      .sel (grant_w),
      .out (mux_out_w)
   );

   always_comb begin
      full_d = full_q;
      prio_d = prio_q;
      msg_d  = msg_q;
      if (xfer_w) begin
         full_d = 1'b1;
         msg_d  = mux_out_w;
         // Favour the requester that just lost.
         prio_d = (grant_w == GRANT_IN0) ? GRANT_IN1 : GRANT_IN0;
      end else if (full_q && out_rdy) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         prio_q <= GRANT_IN0;
         msg_q  <= '0;
      end else begin
         full_q <= full_d;
         prio_q <= prio_d;
         msg_q  <= msg_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux2_rr_arbiter
//  Purpose  : Self-checking bench for mux2_rr_arbiter: directed scenarios
//             followed by randomized producer/consumer traffic, with a
//             scoreboard queue of expected output messages.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in0_val, in1_val, out_rdy;
   logic [7:0] in0_msg, in1_msg;
   logic       in0_rdy, in1_rdy, out_val, sel;
   logic [7:0] out_msg;

   int errors = 0;
   int checks = 0;

   // Reference state: whether a message is buffered, which requester is
   // favoured, and the buffered value. Expected outputs queue in order.
   logic       m_full;
   logic       m_prio;
   logic [7:0] m_msg;
   logic [7:0] sb[$];

   mux2_rr_arbiter #(.nbits(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .in0_val (in0_val),
      .in0_rdy (in0_rdy),
      .in0_msg (in0_msg),
      .in1_val (in1_val),
      .in1_rdy (in1_rdy),
      .in1_msg (in1_msg),
      .out_val (out_val),
      .out_rdy (out_rdy),
      .out_msg (out_msg),
      .sel     (sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: inputs change just after posedge, so mid-cycle the output
   // handshake is settled and describes the transfer on the next edge.
   always @(negedge clk) begin
      if (!reset && out_val && out_rdy) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            check("out_msg_order", {24'd0, out_msg}, {24'd0, sb.pop_front()});
         end
      end
   end

   // One cycle of stimulus with reference-model prediction and checks.
   task automatic step(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1,
                       input logic ordy);
      logic acc, g, e0, e1;
      @(posedge clk); #1;
      in0_val = v0; in0_msg = d0;
      in1_val = v1; in1_msg = d1;
      out_rdy = ordy;
      acc = !m_full || ordy;
      if (v0 && v1)  g = m_prio;
      else if (v0)   g = 1'b0;
      else if (v1)   g = 1'b1;
      else           g = m_prio;
      e0 = acc && v0 && (g == 1'b0);
      e1 = acc && v1 && (g == 1'b1);
      #1;
      check("in0_rdy", {31'd0, in0_rdy}, {31'd0, e0});
      check("in1_rdy", {31'd0, in1_rdy}, {31'd0, e1});
      check("out_val", {31'd0, out_val}, {31'd0, m_full});
      check("sel",     {31'd0, sel},     {31'd0, g});
      if (m_full) check("out_msg_held", {24'd0, out_msg}, {24'd0, m_msg});
      if (e0) begin
         sb.push_back(d0); m_msg = d0; m_full = 1'b1; m_prio = 1'b1;
      end else if (e1) begin
         sb.push_back(d1); m_msg = d1; m_full = 1'b1; m_prio = 1'b0;
      end else if (m_full && ordy) begin
         m_full = 1'b0;
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_full = 1'b0;
      m_prio = 1'b0;
      m_msg  = 8'h00;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
      reset = 1'b1;
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic       p0, p1;
      logic [7:0] q0, q1;
      int         wait0, wait1;
      logic       v0, v1;

      reset = 1'b1;
      in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
      in0_msg = 8'h00; in1_msg = 8'h00;
      model_reset();

      // Reset state, sampled after an edge with reset still high.
      @(posedge clk); #1;
      in0_val = 1'b1; in1_val = 1'b1; out_rdy = 1'b1;
      #1;
      check("rst_out_val", {31'd0, out_val}, 32'd0);
      check("rst_in0_rdy", {31'd0, in0_rdy}, 32'd0);
      check("rst_in1_rdy", {31'd0, in1_rdy}, 32'd0);
      check("rst_sel",     {31'd0, sel},     32'd0);
      check("rst_out_msg", {24'd0, out_msg}, 32'd0);
      in0_val = 1'b0; in1_val = 1'b0;
      reset = 1'b0;

      // Single requester.
      step(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      check("single_in0_rdy", {31'd0, in0_rdy}, 32'd1);
      check("single_sel",     {31'd0, sel},     32'd0);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("single_out_val", {31'd0, out_val}, 32'd1);
      check("single_out_msg", {24'd0, out_msg}, 32'hA5);

      // Contention from a fresh priority state: strict alternation.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
         check("contend_sel", {31'd0, sel}, (i % 2 == 0) ? 32'd0 : 32'd1);
      end

      // Backpressure while full: nothing accepted, output stable.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
         check("bp_in0_rdy",  {31'd0, in0_rdy}, 32'd0);
         check("bp_in1_rdy",  {31'd0, in1_rdy}, 32'd0);
         check("bp_out_msg",  {24'd0, out_msg}, 32'h22);
      end
      // Release: same-cycle dequeue and enqueue, in0 now favoured.
      step(1'b1, 8'h55, 1'b1, 8'h66, 1'b1);
      check("bp_release_in0_rdy", {31'd0, in0_rdy}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("bp_release_out_val", {31'd0, out_val}, 32'd1);
      check("bp_release_out_msg", {24'd0, out_msg}, 32'h55);

      // Alternating idle requesters; priority follows the last winner.
      step(1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
      check("alt_in1_rdy", {31'd0, in1_rdy}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("alt_prio_after_in1", {31'd0, sel}, 32'd0);
      step(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
      check("alt_in0_rdy", {31'd0, in0_rdy}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("alt_prio_after_in0", {31'd0, sel}, 32'd1);
      step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

      // Mid-stream reset with a buffered message; effect must be immediate.
      step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
      step(1'b1, 8'h88, 1'b1, 8'h99, 1'b0);
      @(posedge clk); #3;
      check("pre_rst_full", {31'd0, out_val}, 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_out_val", {31'd0, out_val}, 32'd0);
      check("midrst_in0_rdy", {31'd0, in0_rdy}, 32'd0);
      check("midrst_in1_rdy", {31'd0, in1_rdy}, 32'd0);
      check("midrst_out_msg", {24'd0, out_msg}, 32'd0);
      model_reset();
      @(posedge clk); #1;
      in0_val = 1'b0; in1_val = 1'b0; out_rdy = 1'b0;
      reset = 1'b0;

      // Randomized traffic: each producer holds val and data until granted.
      p0 = 1'b0; p1 = 1'b0; q0 = 8'h00; q1 = 8'h00;
      wait0 = 0; wait1 = 0;
      for (int c = 0; c < 1000; c++) begin
         if (!p0 && ($urandom_range(0, 3) != 0)) begin
            p0 = 1'b1; q0 = 8'($urandom);
         end
         if (!p1 && ($urandom_range(0, 3) != 0)) begin
            p1 = 1'b1; q1 = 8'($urandom);
         end
         v0 = p0; v1 = p1;
         step(v0, p0 ? q0 : 8'($urandom), v1, p1 ? q1 : 8'($urandom),
              1'($urandom_range(0, 2) != 0));
         if (in0_rdy) p0 = 1'b0;
         if (in1_rdy) p1 = 1'b0;
         // Fairness: a held requester sees at most one grant to the other.
         if (v1 && in0_rdy) wait1++;
         if (in1_rdy)       wait1 = 0;
         if (v0 && in1_rdy) wait0++;
         if (in0_rdy)       wait0 = 0;
         if (in0_rdy || in1_rdy) begin
            check("fair_wait_in1", (wait1 > 1) ? 32'd1 : 32'd0, 32'd0);
            check("fair_wait_in0", (wait0 > 1) ? 32'd1 : 32'd0, 32'd0);
         end
      end

      // Drain and confirm every accepted message came out exactly once.
      for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check("drain_sb_empty", sb.size(), 32'd0);
      check("drain_out_val",  {31'd0, out_val}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
